// File: rtl/sign_extend32.sv
// sign_extend32: immediate-field extension unit.
// signExt is a purely combinational sign extension of the 16-bit immediate.
// extOut/outValid/extNeg form a one-stage registered path that applies the
// mode-selected extension, with stall (hold) and valid qualification.
module sign_extend32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] immPartInst,
    input  logic [1:0]  extMode,
    input  logic        inValid,
    input  logic        hold,
    output logic [31:0] signExt,
    output logic [31:0] extOut,
    output logic        outValid,
    output logic        extNeg
);

    // Extension modes
    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic        imm_sign;
    logic [15:0] sign_fill;
    logic [31:0] result_next;
    logic [31:0] ext_out_reg;
    logic        out_valid_reg;
    logic        ext_neg_reg;
    logic        capture;

    assign imm_sign = immPartInst[15];

    // Replicate the immediate's sign bit across the upper half, one bit per lane.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_sign_fill
            assign sign_fill[gi] = imm_sign;
        end
    endgenerate

    // Unregistered sign extension; untouched by reset, clock or mode.
    assign signExt = {sign_fill, immPartInst};

    // Mode-dependent result; every case is plain bit rearrangement.
    always_comb begin
        result_next = 32'h0000_0000;
        case (extMode)
            MODE_SIGN:   result_next = {sign_fill, immPartInst};
            MODE_ZERO:   result_next = {16'h0000, immPartInst};
            MODE_UPPER:  result_next = {immPartInst, 16'h0000};
            // The two sign copies pushed out at the top are simply dropped.
            MODE_BRANCH: result_next = {sign_fill[13:0], immPartInst, 2'b00};
            default:     result_next = 32'h0000_0000;
        endcase
    end

    assign capture = !hold && inValid;

    // Output stage: reset wins, hold freezes everything, otherwise capture or drop valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_out_reg   <= 32'h0000_0000;
            out_valid_reg <= 1'b0;
            ext_neg_reg   <= 1'b0;
        end else if (!hold) begin
            out_valid_reg <= inValid;
            if (capture) begin
                ext_out_reg <= result_next;
                ext_neg_reg <= result_next[31];
            end
        end
    end

    assign extOut   = ext_out_reg;
    assign outValid = out_valid_reg;
    assign extNeg   = ext_neg_reg;

endmodule

// File: tb/tb_sign_extend32.sv
// tb_sign_extend32: directed-vector bench for sign_extend32.
module tb_sign_extend32;

    logic        clk;
    logic        rst_n;
    logic [15:0] immPartInst;
    logic [1:0]  extMode;
    logic        inValid;
    logic        hold;
    logic [31:0] signExt;
    logic [31:0] extOut;
    logic        outValid;
    logic        extNeg;

    int n_vec  = 0;
    int n_miss = 0;

    sign_extend32 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .immPartInst (immPartInst),
        .extMode     (extMode),
        .inValid     (inValid),
        .hold        (hold),
        .signExt     (signExt),
        .extOut      (extOut),
        .outValid    (outValid),
        .extNeg      (extNeg)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector and reports any miscompare.
    task automatic check_vec(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h", tag, observed, expected);
        end else begin
            $display("ok   %s: %08h", tag, observed);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the registered outputs together.
    task automatic check_regs(input string tag, input logic [31:0] exp_out,
                              input logic exp_valid, input logic exp_neg);
        check_vec({tag, ".extOut"}, extOut, exp_out);
        check_vec({tag, ".outValid"}, {31'd0, outValid}, {31'd0, exp_valid});
        check_vec({tag, ".extNeg"}, {31'd0, extNeg}, {31'd0, exp_neg});
    endtask

    // Capture one immediate in one mode and check the result a cycle later.
    task automatic capture_and_check(input string tag, input logic [15:0] imm,
                                     input logic [1:0] mode,
                                     input logic [31:0] exp_out, input logic exp_neg);
        immPartInst = imm;
        extMode     = mode;
        inValid     = 1'b1;
        hold        = 1'b0;
        tick();
        check_regs(tag, exp_out, 1'b1, exp_neg);
    endtask

    logic [15:0] comb_imm [5];
    logic [31:0] comb_exp [5];

    initial begin
        rst_n       = 1'b0;
        immPartInst = 16'h0000;
        extMode     = 2'b00;
        inValid     = 1'b0;
        hold        = 1'b0;
        #2;

        // Reset state
        check_regs("reset", 32'h0000_0000, 1'b0, 1'b0);

        // Combinational path, no clock edge between apply and check
        comb_imm = '{16'h0000, 16'hFFF8, 16'h0007, 16'hFFFF, 16'h0080};
        comb_exp = '{32'h0000_0000, 32'hFFFF_FFF8, 32'h0000_0007,
                     32'hFFFF_FFFF, 32'h0000_0080};
        for (int i = 0; i < 5; i++) begin
            immPartInst = comb_imm[i];
            #1;
            check_vec($sformatf("comb[%0d]", i), signExt, comb_exp[i]);
        end
        immPartInst = 16'h8000; #1;
        check_vec("comb_8000", signExt, 32'hFFFF_8000);
        immPartInst = 16'h7FFF; #1;
        check_vec("comb_7FFF", signExt, 32'h0000_7FFF);

        // Release reset between edges; nothing valid yet
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_regs("idle", 32'h0000_0000, 1'b0, 1'b0);

        // Four modes on consecutive edges
        capture_and_check("mode00", 16'hFFF8, 2'b00, 32'hFFFF_FFF8, 1'b1);
        capture_and_check("mode01", 16'hFFF8, 2'b01, 32'h0000_FFF8, 1'b0);
        capture_and_check("mode10", 16'hFFF8, 2'b10, 32'hFFF8_0000, 1'b1);
        capture_and_check("mode11", 16'hFFF8, 2'b11, 32'hFFFF_FFE0, 1'b1);

        // Boundaries and extra patterns
        capture_and_check("b8000_m00", 16'h8000, 2'b00, 32'hFFFF_8000, 1'b1);
        capture_and_check("b7FFF_m00", 16'h7FFF, 2'b00, 32'h0000_7FFF, 1'b0);
        capture_and_check("bFFFF_m01", 16'hFFFF, 2'b01, 32'h0000_FFFF, 1'b0);
        capture_and_check("bFFFF_m11", 16'hFFFF, 2'b11, 32'hFFFF_FFFC, 1'b1);
        capture_and_check("b8000_m10", 16'h8000, 2'b10, 32'h8000_0000, 1'b1);
        capture_and_check("b1234_m11", 16'h1234, 2'b11, 32'h0000_48D0, 1'b0);
        capture_and_check("b8001_m11", 16'h8001, 2'b11, 32'hFFFE_0004, 1'b1);
        capture_and_check("b1234_m10", 16'h1234, 2'b10, 32'h1234_0000, 1'b0);

        // Hold freezes all registered outputs
        capture_and_check("hold_pre", 16'h0007, 2'b00, 32'h0000_0007, 1'b0);
        hold        = 1'b1;
        immPartInst = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_regs($sformatf("hold[%0d]", i), 32'h0000_0007, 1'b1, 1'b0);
        end
        inValid = 1'b0;
        tick();
        check_regs("hold_noval", 32'h0000_0007, 1'b1, 1'b0);

        // Valid drop: outValid clears, data kept
        hold = 1'b0;
        tick();
        check_regs("vdrop", 32'h0000_0007, 1'b0, 1'b0);
        tick();
        check_regs("vdrop2", 32'h0000_0007, 1'b0, 1'b0);

        // Asynchronous reset between edges
        capture_and_check("pre_rst", 16'hFFFF, 2'b00, 32'hFFFF_FFFF, 1'b1);
        immPartInst = 16'h1234;
        extMode     = 2'b10;
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("async_rst", 32'h0000_0000, 1'b0, 1'b0);
        immPartInst = 16'h0080; #1;
        check_vec("rst_comb", signExt, 32'h0000_0080);

        // Reset dominates pending capture
        tick();
        check_regs("rst_prio", 32'h0000_0000, 1'b0, 1'b0);

        // First capture after reset release
        immPartInst = 16'h0005;
        extMode     = 2'b01;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_regs("post_rst", 32'h0000_0005, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sign_extend32.md
SIGN_EXTEND32 -- requirements
Module: sign_extend32

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (clock) and rst_n (reset).
REQ-002 clk  input  1  rising-edge clock for all registered outputs.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 immPartInst  input  16  immediate field of the instruction.
REQ-005 extMode  input  2  extension mode: 00 sign, 01 zero, 10 upper (LUI), 11 branch offset.
REQ-006 inValid  input  1  qualifies immPartInst/extMode for capture.
REQ-007 hold  input  1  pipeline stall; when 1, registered outputs keep their value.
REQ-008 signExt  output  32  combinational sign extension of immPartInst, independent of clk, rst_n and extMode.
REQ-009 extOut  output  32  registered, mode-dependent extension result.
REQ-010 outValid  output  1  registered; extOut holds a result captured from a valid input.
REQ-011 extNeg  output  1  registered; equals extOut[31].

Function
REQ-012 signExt SHALL equal {16{immPartInst[15]}, immPartInst} at all times, with zero clock latency.
- signExt SHALL not be affected by reset.
REQ-013 The next-value result for each extMode SHALL be:
- mode 00: {16{imm[15]}, imm}.
- mode 01: {16'h0000, imm}.
- mode 10: {imm, 16'h0000}.
- mode 11: sign-extended imm shifted left by 2, i.e. {14{imm[15]}, imm, 2'b00}.
REQ-014 On a rising clk edge with hold=0 and inValid=1, the block SHALL load the mode result into extOut, set outValid=1, and set extNeg=result[31].
- Latency: exactly 1 cycle.
REQ-015 On a rising clk edge with hold=0 and inValid=0, the block SHALL clear outValid to 0 and keep extOut and extNeg unchanged.
REQ-016 On a rising clk edge with hold=1, the block SHALL keep extOut, outValid and extNeg unchanged, regardless of inValid.
REQ-017 All arithmetic SHALL be pure bit rearrangement.
- No overflow detection.
- Bits shifted out in mode 11 are the sign copies and SHALL be discarded.
REQ-018 Boundary values SHALL give the following results:
- imm=16'h8000, mode 00: 32'hFFFF8000.
- imm=16'h7FFF, mode 00: 32'h00007FFF.
- imm=16'hFFFF, mode 01: 32'h0000FFFF.
- imm=16'hFFFF, mode 11: 32'hFFFFFFFC.

Reset
REQ-019 While rst_n=0, the block SHALL force extOut=32'h00000000, outValid=0 and extNeg=0 immediately, without waiting for clk.
REQ-020 Reset SHALL take priority over hold and inValid.
- Reset asserted mid-operation SHALL discard any pending capture.
REQ-021 After rst_n rises, the first capture SHALL occur at the first rising clk edge that meets REQ-014.

Verification
REQ-022 Combinational: immPartInst = 0, -8, 7, -1, 128 in sequence -> signExt = 32'h00000000, 32'hFFFFFFF8, 32'h00000007, 32'hFFFFFFFF, 32'h00000080, each valid with no clock edge.
REQ-023 Modes: imm=16'hFFF8 with inValid=1, extMode 00/01/10/11 on four consecutive edges -> extOut = 32'hFFFFFFF8, 32'h0000FFF8, 32'hFFF80000, 32'hFFFFFFE0 one cycle later, with extNeg = 1, 0, 1, 1.
REQ-024 Hold: capture 16'h0007 (mode 00), then hold=1 and apply 16'h8000 for 3 edges -> extOut stays 32'h00000007 and outValid stays 1.
REQ-025 Valid drop: capture with inValid=1, then inValid=0 -> outValid goes to 0 on the next edge and extOut is unchanged.
REQ-026 Asynchronous reset: after extOut=32'hFFFFFFFF, pull rst_n low between clock edges -> extOut=0, outValid=0 and extNeg=0 immediately, while signExt still tracks immPartInst.
